buzzer_alarm_sched: RTL and testbench
=====================================

Name: buzzer_alarm_sched

Overview:
Alarm scheduler that sits in front of the buzzer tone generator.
- Qualifies the raw "hot" and "cold" alarm requests from the temperature comparators.
- Arbitrates between them by fixed priority and enforces a minimum sound duration.
- Handles operator acknowledge/mute.
- Drives the 2-bit acionar code: 01 = hot pattern, 10 = cold pattern, 00 = silent. Never drives 11.

Parameters:
TICK_CYCLES, 50000, clk cycles per 1 ms tick (50 MHz clk).
QUAL_MS, 50, ms a request must be held continuously before it is qualified; 0 = qualified immediately.
MIN_ON_MS, 2000, minimum ms an alarm code stays asserted once started or preempted.
MUTE_MS, 30000, ms of silence after acknowledge.
All ms parameters are ≤ 65535. Ms counters are 16 bits; the tick divider is 16 bits.

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  reset, asynchronous, active-low
enable  input  1  1 = scheduler active; 0 = force silent and idle
req_hot  input  1  hot-limit request, synchronous to clk
req_cold  input  1  cold-limit request, synchronous to clk
ack  input  1  operator acknowledge, single-cycle pulse, already debounced
acionar  output  2  pattern code to the buzzer: 00 / 01 / 10
alarm_active  output  1  registered; 1 while acionar != 00
muted  output  1  registered; 1 in the MUTED state
alarm_count  output  8  count of alarm starts and preemptions, saturating at 255

Behaviour:
- Reset: all of the following are cleared.
  - state = IDLE, acionar = 00, alarm_active = 0, muted = 0, alarm_count = 0.
  - All counters = 0, including the tick divider.
- Tick divider:
  - Free-running; counts 0..TICK_CYCLES-1.
  - tick = 1 for the one cycle where the count equals TICK_CYCLES-1.
- Qualification (independent per request):
  - qcnt increments on tick while the request = 1, saturating at QUAL_MS.
  - qcnt clears on any clk where the request = 0.
  - qual_x = req_x && (qcnt_x >= QUAL_MS).
  - enable = 0 clears both qcnt.
- Priority: hot > cold.
  - want = 01 if qual_hot; else 10 if qual_cold; else 00.
- All outputs are registered and change on the same edge as the state.
- State machine:
  - IDLE:
    - If want != 00: go to ALARM, acionar = want, on_cnt = 0, alarm_count += 1.
    - ack is ignored.
  - ALARM:
    - on_cnt increments on tick, saturating at MIN_ON_MS.
    - Preempt: if acionar = 10 and qual_hot, then acionar = 01 on the next edge, on_cnt = 0, alarm_count += 1. Preemption is allowed regardless of on_cnt.
    - Exit: if on_cnt >= MIN_ON_MS and the active code's request is not qualified:
      - want = 00: go to IDLE, acionar = 00.
      - want != 00: switch to want, on_cnt = 0, alarm_count += 1.
    - A cold request during a hot alarm produces no change while hot remains.
    - ack = 1: go to MUTED, acionar = 00, mute_cnt = 0. ack takes precedence over preempt/exit in the same cycle.
  - MUTED:
    - muted = 1, acionar = 00; mute_cnt increments on tick.
    - When mute_cnt reaches MUTE_MS: go to IDLE, which re-evaluates want on the following cycle.
    - Exception: if the alarm was muted on code 10 and qual_hot rises, go to ALARM with 01 immediately, muted = 0, alarm_count += 1.
    - ack in MUTED is ignored; the mute timer does not restart.
- enable = 0, any state: on the next edge go to IDLE with acionar = 00, muted = 0, on_cnt = 0, mute_cnt = 0. alarm_count is held.
- Reset mid-alarm: outputs go silent asynchronously; the scheduler restarts in IDLE with counters cleared.
- Latency: a request asserted at cycle N with QUAL_MS = 0 gives acionar valid at edge N+1.

Test Plan:
Bench parameters: TICK_CYCLES=10, QUAL_MS=3, MIN_ON_MS=5, MUTE_MS=8.
1. Qualification: req_cold held 2 ticks then dropped → acionar stays 00. req_cold held ≥3 ticks → acionar = 10 one cycle after qcnt reaches 3; alarm_count = 1.
2. Minimum on-time: cold alarm started, req_cold dropped after 1 tick → acionar stays 10 until on_cnt = 5 ticks, then 00. Same test with req_cold still held at 5 ticks → stays 10.
3. Preempt: during a cold alarm, req_hot qualifies → acionar = 01 on the next edge, alarm_count = 2. Drop hot with cold still qualified after 5 ticks → acionar = 10, alarm_count = 3.
4. Mute:
   - ack during a hot alarm → acionar = 00, muted = 1. Second ack has no effect. After 8 ticks → muted = 0, then acionar = 01 one cycle later if req_hot is still held.
   - Muted cold alarm plus qualified hot → acionar = 01 immediately.
5. Simultaneous: req_hot and req_cold qualify on the same cycle → acionar = 01, never 11. ack and preempt on the same cycle → MUTED.
6. enable = 0 mid-alarm → acionar = 00 next edge, alarm_count held. rst_n pulse mid-alarm → all outputs 0 asynchronously.

Source files
------------

// File: rtl/buzzer_alarm_sched.sv
// Alarm scheduler in front of the buzzer tone generator: qualifies hot/cold
// requests, arbitrates hot over cold, enforces minimum on-time and handles mute.
module buzzer_alarm_sched #(
  parameter int unsigned TICK_CYCLES = 50000,
  parameter int unsigned QUAL_MS     = 50,
  parameter int unsigned MIN_ON_MS   = 2000,
  parameter int unsigned MUTE_MS     = 30000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       req_hot,
  input  logic       req_cold,
  input  logic       ack,
  output logic [1:0] acionar,
  output logic       alarm_active,
  output logic       muted,
  output logic [7:0] alarm_count
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_CYCLES - 1);
  localparam logic [15:0] QUAL_LIM  = 16'(QUAL_MS);
  localparam logic [15:0] MIN_LIM   = 16'(MIN_ON_MS);
  localparam logic [15:0] MUTE_LIM  = 16'(MUTE_MS);

  localparam logic [1:0] CODE_OFF  = 2'b00;
  localparam logic [1:0] CODE_HOT  = 2'b01;
  localparam logic [1:0] CODE_COLD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALARM = 2'd1,
    MUTED = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [15:0] div_cnt;
  logic        tick;
  logic [15:0] qcnt_hot, qcnt_cold;
  logic        qual_hot, qual_cold;
  logic [1:0]  want;
  logic        active_qual;
  logic [15:0] on_cnt, on_cnt_nx;
  logic [15:0] mute_cnt, mute_cnt_nx;
  logic [1:0]  acionar_nx;
  logic [1:0]  muted_code, muted_code_nx;
  logic        count_inc;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic [15:0] lim);
    return (v < lim) ? v + 16'd1 : v;
  endfunction

  // 1 ms tick divider, free-running regardless of enable
  assign tick = (div_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Request qualification: continuous hold counted in ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt_hot  <= '0;
      qcnt_cold <= '0;
    end else begin
      if (!enable || !req_hot) begin
        qcnt_hot <= '0;
      end else if (tick) begin
        qcnt_hot <= sat_inc16(qcnt_hot, QUAL_LIM);
      end
      if (!enable || !req_cold) begin
        qcnt_cold <= '0;
      end else if (tick) begin
        qcnt_cold <= sat_inc16(qcnt_cold, QUAL_LIM);
      end
    end
  end

  assign qual_hot    = req_hot  && (qcnt_hot  >= QUAL_LIM);
  assign qual_cold   = req_cold && (qcnt_cold >= QUAL_LIM);
  assign want        = qual_hot ? CODE_HOT : (qual_cold ? CODE_COLD : CODE_OFF);
  assign active_qual = (acionar == CODE_HOT) ? qual_hot : qual_cold;

  always_comb begin
    state_nx      = state;
    acionar_nx    = acionar;
    on_cnt_nx     = on_cnt;
    mute_cnt_nx   = mute_cnt;
    muted_code_nx = muted_code;
    count_inc     = 1'b0;
    if (!enable) begin
      state_nx    = IDLE;
      acionar_nx  = CODE_OFF;
      on_cnt_nx   = '0;
      mute_cnt_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (want != CODE_OFF) begin
            state_nx   = ALARM;
            acionar_nx = want;
            on_cnt_nx  = '0;
            count_inc  = 1'b1;
          end
        end
        ALARM: begin
          if (tick) on_cnt_nx = sat_inc16(on_cnt, MIN_LIM);
          // ack beats preempt, preempt beats the minimum-on exit
          if (ack) begin
            state_nx      = MUTED;
            acionar_nx    = CODE_OFF;
            mute_cnt_nx   = '0;
            muted_code_nx = acionar;
          end else if (acionar == CODE_COLD && qual_hot) begin
            acionar_nx = CODE_HOT;
            on_cnt_nx  = '0;
            count_inc  = 1'b1;
          end else if (on_cnt >= MIN_LIM && !active_qual) begin
            if (want == CODE_OFF) begin
              state_nx   = IDLE;
              acionar_nx = CODE_OFF;
            end else begin
              acionar_nx = want;
              on_cnt_nx  = '0;
              count_inc  = 1'b1;
            end
          end
        end
        MUTED: begin
          if (tick) mute_cnt_nx = sat_inc16(mute_cnt, MUTE_LIM);
          // a hot fault breaks through a muted cold alarm at once
          if (muted_code == CODE_COLD && qual_hot) begin
            state_nx   = ALARM;
            acionar_nx = CODE_HOT;
            on_cnt_nx  = '0;
            count_inc  = 1'b1;
          end else if (mute_cnt >= MUTE_LIM) begin
            state_nx = IDLE;
          end
        end
        default: begin
          state_nx   = IDLE;
          acionar_nx = CODE_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acionar      <= CODE_OFF;
      alarm_active <= 1'b0;
      muted        <= 1'b0;
      alarm_count  <= '0;
      on_cnt       <= '0;
      mute_cnt     <= '0;
      muted_code   <= CODE_OFF;
    end else begin
      state        <= state_nx;
      acionar      <= acionar_nx;
      alarm_active <= (acionar_nx != CODE_OFF);
      muted        <= (state_nx == MUTED);
      on_cnt       <= on_cnt_nx;
      mute_cnt     <= mute_cnt_nx;
      muted_code   <= muted_code_nx;
      if (count_inc) alarm_count <= sat_inc8(alarm_count);
    end
  end

endmodule

// File: tb/tb_buzzer_alarm_sched.sv
// Directed table-driven bench for buzzer_alarm_sched with small tick/ms parameters.
module tb_buzzer_alarm_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       req_hot = 1'b0;
  logic       req_cold = 1'b0;
  logic       ack = 1'b0;
  logic [1:0] acionar;
  logic       alarm_active;
  logic       muted;
  logic [7:0] alarm_count;

  int tests = 0;
  int fails = 0;

  buzzer_alarm_sched #(
    .TICK_CYCLES(10),
    .QUAL_MS(3),
    .MIN_ON_MS(5),
    .MUTE_MS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .req_hot(req_hot),
    .req_cold(req_cold),
    .ack(ack),
    .acionar(acionar),
    .alarm_active(alarm_active),
    .muted(muted),
    .alarm_count(alarm_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       en;
    bit       hot;
    bit       cold;
    bit       ack;
    int       n;
    bit [1:0] exp_code;
    bit       exp_act;
    bit       exp_mut;
    bit [7:0] exp_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit en, bit hot, bit cold, bit a, int n,
                              bit [1:0] code, bit act, bit mut, bit [7:0] cnt);
    vec_t v;
    v.en = en; v.hot = hot; v.cold = cold; v.ack = a; v.n = n;
    v.exp_code = code; v.exp_act = act; v.exp_mut = mut; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input bit [1:0] code, input bit act,
                               input bit mut, input bit [7:0] cnt);
    check({tag, ".acionar"},      32'(acionar),      32'(code));
    check({tag, ".alarm_active"}, 32'(alarm_active), 32'(act));
    check({tag, ".muted"},        32'(muted),        32'(mut));
    check({tag, ".alarm_count"},  32'(alarm_count),  32'(cnt));
  endtask

  always @(negedge clk) begin
    if (rst_n && acionar == 2'b11) begin
      fails++;
      $display("FAIL never_11: got acionar %0b, expected not 11", acionar);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Cycle numbers in comments count posedges since reset release; ticks land on multiples of 10.
    vq.push_back(mk(1,0,1,0,25, 2'b00,0,0,8'd0));  // 25: cold held only 2 ticks
    vq.push_back(mk(1,0,0,0,10, 2'b00,0,0,8'd0));  // 35
    vq.push_back(mk(1,0,1,0,25, 2'b00,0,0,8'd0));  // 60: qcnt reaches 3
    vq.push_back(mk(1,0,1,0, 1, 2'b10,1,0,8'd1));  // 61: cold alarm starts
    vq.push_back(mk(1,0,1,0,11, 2'b10,1,0,8'd1));  // 72
    vq.push_back(mk(1,0,0,0,38, 2'b10,1,0,8'd1));  // 110: on_cnt hits 5
    vq.push_back(mk(1,0,0,0, 1, 2'b00,0,0,8'd1));  // 111: released
    vq.push_back(mk(1,0,1,0,29, 2'b00,0,0,8'd1));  // 140
    vq.push_back(mk(1,0,1,0, 1, 2'b10,1,0,8'd2));  // 141
    vq.push_back(mk(1,0,1,0,59, 2'b10,1,0,8'd2));  // 200: held past minimum
    vq.push_back(mk(1,1,1,0,30, 2'b10,1,0,8'd2));  // 230
    vq.push_back(mk(1,1,1,0, 1, 2'b01,1,0,8'd3));  // 231: preempt to hot
    vq.push_back(mk(1,0,1,0,49, 2'b01,1,0,8'd3));  // 280
    vq.push_back(mk(1,0,1,0, 1, 2'b10,1,0,8'd4));  // 281: back to cold
    vq.push_back(mk(1,1,1,0,29, 2'b10,1,0,8'd4));  // 310
    vq.push_back(mk(1,1,1,0, 1, 2'b01,1,0,8'd5));  // 311: preempt before min-on
    vq.push_back(mk(1,1,0,1, 1, 2'b00,0,1,8'd5));  // 312: ack on hot
    vq.push_back(mk(1,1,0,0,12, 2'b00,0,1,8'd5));  // 324
    vq.push_back(mk(1,1,0,1, 1, 2'b00,0,1,8'd5));  // 325: second ack ignored
    vq.push_back(mk(1,1,0,0,65, 2'b00,0,1,8'd5));  // 390: mute_cnt = 8
    vq.push_back(mk(1,1,0,0, 1, 2'b00,0,0,8'd5));  // 391: IDLE
    vq.push_back(mk(1,1,0,0, 1, 2'b01,1,0,8'd6));  // 392: hot re-alarms
    vq.push_back(mk(1,0,1,0,48, 2'b01,1,0,8'd6));  // 440
    vq.push_back(mk(1,0,1,0, 1, 2'b10,1,0,8'd7));  // 441
    vq.push_back(mk(1,0,1,1, 1, 2'b00,0,1,8'd7));  // 442: mute cold
    vq.push_back(mk(1,1,1,0,28, 2'b00,0,1,8'd7));  // 470
    vq.push_back(mk(1,1,1,0, 1, 2'b01,1,0,8'd8));  // 471: hot breaks mute
    vq.push_back(mk(0,1,1,0, 1, 2'b00,0,0,8'd8));  // 472: disable, count held
    vq.push_back(mk(1,0,0,0, 7, 2'b00,0,0,8'd8));  // 479
    vq.push_back(mk(1,1,1,0,21, 2'b00,0,0,8'd8));  // 500
    vq.push_back(mk(1,1,1,0, 1, 2'b01,1,0,8'd9));  // 501: simultaneous -> hot
    vq.push_back(mk(1,0,1,0,49, 2'b01,1,0,8'd9));  // 550
    vq.push_back(mk(1,0,1,0, 1, 2'b10,1,0,8'd10)); // 551
    vq.push_back(mk(1,1,1,0,29, 2'b10,1,0,8'd10)); // 580
    vq.push_back(mk(1,1,1,1, 1, 2'b00,0,1,8'd10)); // 581: ack with preempt
    vq.push_back(mk(1,1,1,0, 1, 2'b01,1,0,8'd11)); // 582: hot over muted cold

    @(negedge clk);
    check_outputs("in_reset", 2'b00, 0, 0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs("reset", 2'b00, 0, 0, 8'd0);

    for (int i = 0; i < vq.size(); i++) begin
      enable   = vq[i].en;
      req_hot  = vq[i].hot;
      req_cold = vq[i].cold;
      ack      = vq[i].ack;
      repeat (vq[i].n) @(posedge clk);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vq[i].exp_code, vq[i].exp_act,
                    vq[i].exp_mut, vq[i].exp_cnt);
    end
    ack = 1'b0;

    // Asynchronous reset in the middle of a hot alarm
    #2 rst_n = 1'b0;
    #1 check_outputs("async_rst", 2'b00, 0, 0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    check_outputs("rst_held", 2'b00, 0, 0, 8'd0);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check_outputs("post_rst_qual", 2'b00, 0, 0, 8'd0);
    @(posedge clk);
    @(negedge clk);
    check_outputs("post_rst_alarm", 2'b01, 1, 0, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
